// File: rtl/alu_issue_stage.sv
// alu_issue_stage: MIPS decode/issue register driving the 5-bit ALU operation interface
// Ports: clk, rst (sync active-high); upstream in_valid/in_ready with instr, rs_data, rt_data;
//        downstream out_valid/out_ready with registered alu_op, alu_in1, alu_in2, shift_amount, illegal.
// Optional: define ALU_ISSUE_ILLEGAL_EN to register illegal; otherwise illegal is tied to 0.
module alu_issue_stage #(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [4:0]  shift_amount,
    output logic        illegal
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [5:0]  opc, fn;
    logic [4:0]  d_op, d_sh;
    logic [31:0] d_in1, d_in2, simm, zimm;
    logic        d_ill, d_md, cap, unused_rs;

    assign opc       = instr[31:26];
    assign fn        = instr[5:0];
    assign simm      = {{16{instr[15]}}, instr[15:0]};
    assign zimm      = {16'h0000, instr[15:0]};
    assign unused_rs = ^instr[25:21];
    assign d_md      = opc == 6'h00 && (fn == 6'h18 || fn == 6'h1A);
    assign in_ready  = state == EMPTY || (state == FULL && out_ready);
    assign out_valid = state == FULL;
    assign cap       = in_valid && in_ready;

    always_comb begin
        d_op  = 5'b00000;
        d_in1 = rs_data;
        d_in2 = rt_data;
        d_sh  = 5'd0;
        d_ill = 1'b0;
        case (opc)
            6'h00: case (fn)
                6'h00:        begin d_op = 5'b00001; d_sh = instr[10:6]; end
                6'h02:        begin d_op = 5'b00010; d_sh = instr[10:6]; end
                6'h03:        begin d_op = 5'b00011; d_sh = instr[10:6]; end
                6'h04:        d_op = 5'b11001;
                6'h06:        d_op = 5'b11010;
                6'h08:        d_op = 5'b01100;
                6'h18:        d_op = 5'b00110;
                6'h1A:        d_op = 5'b00111;
                6'h20, 6'h21: d_op = 5'b00100;
                6'h22, 6'h23: d_op = 5'b00101;
                6'h24:        d_op = 5'b01010;
                6'h25:        d_op = 5'b01000;
                6'h26:        d_op = 5'b00000;
                6'h27:        d_op = 5'b01001;
                6'h2A:        d_op = 5'b01011;
                default:      d_ill = 1'b1;
            endcase
            6'h01:                      if (instr[20:16] == 5'd1) d_op = 5'b10001; else d_ill = 1'b1;
            6'h04:                      d_op = 5'b01101;
            6'h05:                      d_op = 5'b01110;
            6'h06:                      d_op = 5'b01111;
            6'h07:                      d_op = 5'b10000;
            6'h08, 6'h09, 6'h23, 6'h2B: begin d_op = 5'b00100; d_in2 = simm; end
            6'h0A:                      begin d_op = 5'b01011; d_in2 = simm; end
            6'h0C:                      begin d_op = 5'b01010; d_in2 = zimm; end
            6'h0D:                      begin d_op = 5'b01000; d_in2 = zimm; end
            6'h0E:                      begin d_op = 5'b00000; d_in2 = zimm; end
            6'h0F:                      begin d_op = 5'b10010; d_in2 = zimm; end
            default:                    d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_in1 = 32'd0;
            d_in2 = 32'd0;
        end
    end

    // MULT/DIV park in HOLD with the operation already registered; the counter
    // expires one cycle before out_valid so total latency equals MULDIV_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            cnt          <= 4'd0;
            alu_op       <= 5'd0;
            alu_in1      <= 32'd0;
            alu_in2      <= 32'd0;
            shift_amount <= 5'd0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            illegal      <= 1'b0;
`endif
        end else if (cap) begin
            state        <= (d_md && MULDIV_CYCLES > 1) ? HOLD : FULL;
            cnt          <= d_md ? 4'(MULDIV_CYCLES - 1) : 4'd0;
            alu_op       <= d_op;
            alu_in1      <= d_in1;
            alu_in2      <= d_in2;
            shift_amount <= d_sh;
`ifdef ALU_ISSUE_ILLEGAL_EN
            illegal      <= d_ill;
`endif
        end else if (state == HOLD) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= FULL;
        end else if (out_valid && out_ready) begin
            state <= EMPTY;
        end
    end

`ifndef ALU_ISSUE_ILLEGAL_EN
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed bench for alu_issue_stage with a timestamp-based reference model
module tb_alu_issue_stage;
    localparam int MD = 4;
`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        ill;
        logic        md;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = 32'd0, rs_data = 32'd0, rt_data = 32'd0;
    logic        in_ready, out_valid, illegal;
    logic [4:0]  alu_op, shift_amount;
    logic [31:0] alu_in1, alu_in2;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.MULDIV_CYCLES(MD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .shift_amount(shift_amount), .illegal(illegal)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", n, a, e, $time);
        end
    endtask

    function automatic exp_t dec(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic [5:0] o, f;
        logic [31:0] simm, zimm;
        o = i[31:26];
        f = i[5:0];
        simm = {{16{i[15]}}, i[15:0]};
        zimm = {16'h0000, i[15:0]};
        e = '{op: 5'd0, a: rs, b: rt, sh: 5'd0, ill: 1'b0, md: 1'b0};
        if (o == 6'h00) begin
            case (f)
                6'h00: begin e.op = 5'b00001; e.sh = i[10:6]; end
                6'h02: begin e.op = 5'b00010; e.sh = i[10:6]; end
                6'h03: begin e.op = 5'b00011; e.sh = i[10:6]; end
                6'h04: e.op = 5'b11001;
                6'h06: e.op = 5'b11010;
                6'h08: e.op = 5'b01100;
                6'h18: begin e.op = 5'b00110; e.md = 1'b1; end
                6'h1A: begin e.op = 5'b00111; e.md = 1'b1; end
                6'h20, 6'h21: e.op = 5'b00100;
                6'h22, 6'h23: e.op = 5'b00101;
                6'h24: e.op = 5'b01010;
                6'h25: e.op = 5'b01000;
                6'h26: e.op = 5'b00000;
                6'h27: e.op = 5'b01001;
                6'h2A: e.op = 5'b01011;
                default: e.ill = 1'b1;
            endcase
        end else if (o == 6'h01) begin
            if (i[20:16] == 5'd1) e.op = 5'b10001; else e.ill = 1'b1;
        end else if (o == 6'h04) e.op = 5'b01101;
        else if (o == 6'h05) e.op = 5'b01110;
        else if (o == 6'h06) e.op = 5'b01111;
        else if (o == 6'h07) e.op = 5'b10000;
        else if (o == 6'h08 || o == 6'h09 || o == 6'h23 || o == 6'h2B) begin e.op = 5'b00100; e.b = simm; end
        else if (o == 6'h0A) begin e.op = 5'b01011; e.b = simm; end
        else if (o == 6'h0C) begin e.op = 5'b01010; e.b = zimm; end
        else if (o == 6'h0D) begin e.op = 5'b01000; e.b = zimm; end
        else if (o == 6'h0E) begin e.op = 5'b00000; e.b = zimm; end
        else if (o == 6'h0F) begin e.op = 5'b10010; e.b = zimm; end
        else e.ill = 1'b1;
        if (e.ill) begin e.op = 5'd0; e.a = 32'd0; e.b = 32'd0; e.sh = 5'd0; end
        return e;
    endfunction

    // Model: one slot holding the last accepted op and the cycle index from which it is visible.
    int   t = 0, rdy_at = 0;
    bit   occ = 1'b0, clr = 1'b0, armed = 1'b0, eov, eir;
    exp_t m = '0;

    always @(negedge clk) begin
        t++;
        eov = occ && t >= rdy_at;
        eir = !occ || (eov && out_ready);
        if (armed) begin
            chk("m_out_valid", 32'(out_valid), 32'(eov));
            chk("m_in_ready", 32'(in_ready), 32'(eir));
            if (eov || clr) begin
                chk("m_alu_op", 32'(alu_op), 32'(m.op));
                chk("m_alu_in1", alu_in1, m.a);
                chk("m_alu_in2", alu_in2, m.b);
                chk("m_shamt", 32'(shift_amount), 32'(m.sh));
                chk("m_illegal", 32'(illegal), 32'(ILL_EN & m.ill));
            end
        end
        if (rst) begin
            occ = 1'b0; clr = 1'b1; m = '0; armed = 1'b1;
        end else if (armed && in_valid && eir) begin
            occ = 1'b1; clr = 1'b0;
            m = dec(instr, rs_data, rt_data);
            rdy_at = t + (m.md ? MD : 1);
        end else if (armed && eov && out_ready) begin
            occ = 1'b0;
        end
    end

    task automatic put(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; instr = i; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] stream [8] = '{32'h00221824, 32'h00221825, 32'h00221826, 32'h00221827,
                                32'h0022182A, 32'h00221822, 32'h00021942, 32'h00021FC3};
    logic [31:0] mix [20] = '{32'h3C051234, 32'h10220005, 32'h04010003, 32'h04000003,
                              32'h03E00008, 32'h00221804, 32'h8C22FFF0, 32'h3822ABCD,
                              32'h2822FFFF, 32'h0022183F, 32'hAC220004, 32'h14220001,
                              32'h18200001, 32'h1C200001, 32'h3022F00F, 32'h2422000F,
                              32'h00221821, 32'h00221823, 32'h00221806, 32'h0022001A};

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t p;
        bit acc;
        p = dec(32'h012A4020, 32'd5, 32'd7);
        chk("pin_add_op", 32'(p.op), 32'(5'b00100));
        p = dec(32'h2022FFFC, 32'd10, 32'd0);
        chk("pin_addi_in2", p.b, 32'hFFFFFFFC);
        p = dec(32'h34228001, 32'd3, 32'd9);
        chk("pin_ori_in2", p.b, 32'h00008001);
        p = dec(32'hFC000000, 32'd1, 32'd2);
        chk("pin_ill_in1", p.a, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_in1", alu_in1, 32'd0);
        chk("rst_in2", alu_in2, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        put(32'h012A4020, 32'd5, 32'd7);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_op", 32'(alu_op), 32'(5'b00100));
        chk("add_in1", alu_in1, 32'd5);
        chk("add_in2", alu_in2, 32'd7);
        chk("add_shamt", 32'(shift_amount), 32'd0);

        put(32'h2022FFFC, 32'd10, 32'd99);
        chk("addi_op", 32'(alu_op), 32'(5'b00100));
        chk("addi_in1", alu_in1, 32'd10);
        chk("addi_in2", alu_in2, 32'hFFFFFFFC);

        put(32'h34228001, 32'd3, 32'd99);
        chk("ori_op", 32'(alu_op), 32'(5'b01000));
        chk("ori_in2", alu_in2, 32'h00008001);

        put(32'h000940C0, 32'd0, 32'h80);
        chk("sll_op", 32'(alu_op), 32'(5'b00001));
        chk("sll_shamt", 32'(shift_amount), 32'd3);

        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; instr = stream[k]; rs_data = $urandom; rt_data = $urandom;
            @(posedge clk); #1;
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;

        put(32'h00850018, 32'd6, 32'd9);
        for (int k = 0; k < 3; k++) begin
            chk("mult_hold_ready", 32'(in_ready), 32'd0);
            chk("mult_hold_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("mult_valid", 32'(out_valid), 32'd1);
        chk("mult_op", 32'(alu_op), 32'(5'b00110));
        chk("mult_in1", alu_in1, 32'd6);

        put(32'h0085001A, 32'd12, 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("hrst_valid", 32'(out_valid), 32'd0);
        chk("hrst_op", 32'(alu_op), 32'd0);
        chk("hrst_in1", alu_in1, 32'd0);
        chk("hrst_in2", alu_in2, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("hrst_valid_late", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        put(32'h012A4020, 32'd11, 32'd22);
        in_valid = 1'b1; instr = 32'h34228001; rs_data = 32'd3; rt_data = 32'd4;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_op", 32'(alu_op), 32'(5'b00100));
            chk("bp_in1", alu_in1, 32'd11);
            chk("bp_in2", alu_in2, 32'd22);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_new_op", 32'(alu_op), 32'(5'b01000));
        chk("bp_new_in2", alu_in2, 32'h00008001);

        put(32'hFC221800, 32'd123, 32'd456);
        chk("ill_op", 32'(alu_op), 32'd0);
        chk("ill_in1", alu_in1, 32'd0);
        chk("ill_in2", alu_in2, 32'd0);
        chk("ill_flag", 32'(illegal), 32'(ILL_EN));

        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; instr = mix[k]; rs_data = $urandom; rt_data = $urandom;
            for (int w = 0; w < 50; w++) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                acc = in_ready;
                @(posedge clk); #1;
                if (acc) break;
                if (w == 49) chk("mix_accept_timeout", 32'd0, 32'd1);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
